// File: rtl/address_bus_arbiter_pkg.sv
// rtl/address_bus_arbiter_pkg.sv - shared constants and state type for the address bus arbiter
package address_bus_arbiter_pkg;

    localparam int ADDR_SIZE   = 19;
    localparam int ARB_NUM_REQ = 3;
    localparam int ARB_TIMEOUT = 16;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/address_bus_arbiter_rr_pick.sv
// rtl/address_bus_arbiter_rr_pick.sv - combinational round-robin priority picker
module address_bus_arbiter_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] slot;
    logic             found;

    // Scan from ptr upward with wrap; the first eligible slot wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        sum    = '0;
        slot   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            end
            slot = sum[IDX_W-1:0];
            if (!found && eligible[slot]) begin
                found        = 1'b1;
                onehot[slot] = 1'b1;
                idx          = slot;
            end
        end
        any = found;
    end

endmodule

// File: rtl/address_bus_arbiter.sv
// rtl/address_bus_arbiter.sv - round-robin arbiter sharing the CPU address bus between requesters
module address_bus_arbiter #(
    parameter int ADDR_SIZE = address_bus_arbiter_pkg::ADDR_SIZE,
    parameter int NUM_REQ   = address_bus_arbiter_pkg::ARB_NUM_REQ,
    parameter int TIMEOUT   = address_bus_arbiter_pkg::ARB_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]             req_we,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             done,
    output logic [NUM_REQ-1:0]             err,
    output logic [ADDR_SIZE-1:0]           mem_addr,
    output logic                           mem_we,
    output logic                           mem_valid,
    input  logic                           mem_ready,
    output logic                           busy
);

    import address_bus_arbiter_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit TO_EN = (TIMEOUT != 0);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ADDR_SIZE-1:0]  addr_q, addr_d;
    logic                  we_q, we_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]    mask_q, mask_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic [NUM_REQ-1:0]    err_q, err_d;

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [ADDR_SIZE-1:0]  pick_addr;
    logic                  pick_we;
    logic [NUM_REQ-1:0]    idx_onehot;
    logic [IDX_W-1:0]      ptr_next;
    logic                  timeout_hit;

    // The just-finished requester is masked for one IDLE cycle so it can drop req.
    assign eligible = req & ~mask_q;

    address_bus_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .eligible (eligible),
        .ptr      (rr_ptr_q),
        .onehot   (pick_onehot),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    // Select the winning requester's address and write flag.
    always_comb begin
        pick_addr = '0;
        pick_we   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                pick_addr = req_addr[i*ADDR_SIZE +: ADDR_SIZE];
                pick_we   = req_we[i];
            end
        end
    end

    assign idx_onehot  = NUM_REQ'(1) << idx_q;
    assign ptr_next    = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
    assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

    // Next-state logic: arbitrate in IDLE, wait for ready or timeout in ISSUE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        mask_d   = '0;
        done_d   = '0;
        err_d    = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_ISSUE;
                    idx_d   = pick_idx;
                    addr_d  = pick_addr;
                    we_d    = pick_we;
                    cnt_d   = '0;
                end
            end
            ARB_ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_ready) begin
                    state_d  = ARB_IDLE;
                    done_d   = idx_onehot;
                    mask_d   = idx_onehot;
                    rr_ptr_d = ptr_next;
                    cnt_d    = '0;
                end else if (timeout_hit) begin
                    state_d  = ARB_IDLE;
                    err_d    = idx_onehot;
                    mask_d   = idx_onehot;
                    rr_ptr_d = ptr_next;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and latched transaction registers; reset aborts any transaction silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            idx_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            mask_q   <= '0;
            done_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            mask_q   <= mask_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Bus-side outputs decode straight from the state register so reset drops them at once.
    assign busy      = (state_q == ARB_ISSUE);
    assign mem_valid = busy;
    assign mem_we    = busy & we_q;
    assign mem_addr  = addr_q;
    assign gnt       = busy ? idx_onehot : '0;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_address_bus_arbiter.sv
// tb/tb_address_bus_arbiter.sv - directed self-checking bench for address_bus_arbiter
module tb_address_bus_arbiter;

    localparam int AW = 19;
    localparam int NR = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_we;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     done;
    logic [NR-1:0]     err;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic              mem_valid;
    logic              mem_ready;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    address_bus_arbiter #(
        .ADDR_SIZE (AW),
        .NUM_REQ   (NR),
        .TIMEOUT   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    logic [AW-1:0] t2_addr [NR];
    logic [NR-1:0] t2_we;
    logic          prev_busy;
    int            exp_i;
    int            n;

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req_addr  = '0;
        req_we    = '0;
        mem_ready = 1'b0;

        step;
        step;
        check("rst gnt", gnt, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        check("rst mem_valid", mem_valid, 0);
        check("rst mem_we", mem_we, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst busy", busy, 0);
        rst_n = 1'b1;

        // single request, zero-wait memory
        set_addr(0, 19'h1_2345);
        mem_ready = 1'b1;
        req = 3'b001;
        step;
        check("t1 gnt", gnt, 3'b001);
        check("t1 mem_addr", mem_addr, 19'h1_2345);
        check("t1 mem_valid", mem_valid, 1);
        check("t1 busy", busy, 1);
        step;
        check("t1 done", done, 3'b001);
        check("t1 busy off", busy, 0);
        check("t1 gnt off", gnt, 0);
        req = 3'b000;
        step;
        check("t1 done once", done, 0);
        check("t1 idle", busy, 0);

        // one requester held high: ISSUE, done bubble, masked-free IDLE, repeat
        set_addr(1, 19'h2_0202);
        req = 3'b010;
        prev_busy = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step;
            check("t5 gnt", gnt, (k % 3 == 1) ? 3'b010 : 3'b000);
            check("t5 done", done, (k % 3 == 2) ? 3'b010 : 3'b000);
            check("t5 back2back", busy & prev_busy, 0);
            prev_busy = busy;
        end
        req = 3'b000;
        mem_ready = 1'b0;
        step;
        check("t5 idle", busy, 0);

        // ready arrives in the last cycle before timeout
        set_addr(2, 19'h4_0004);
        req_we = 3'b100;
        req = 3'b100;
        for (int k = 1; k <= 4; k++) begin
            step;
            check("t4 busy", busy, 1);
            check("t4 err", err, 0);
            if (k == 4) mem_ready = 1'b1;
        end
        step;
        check("t4 done", done, 3'b100);
        check("t4 no err", err, 0);
        check("t4 busy off", busy, 0);
        mem_ready = 1'b0;
        req = 3'b000;
        step;

        // timeout with write flag
        set_addr(2, 19'h3_3333);
        req = 3'b100;
        for (int k = 1; k <= 4; k++) begin
            step;
            check("t3 mem_valid", mem_valid, 1);
            check("t3 mem_we", mem_we, 1);
            check("t3 gnt", gnt, 3'b100);
            check("t3 mem_addr", mem_addr, 19'h3_3333);
            check("t3 err early", err, 0);
        end
        step;
        check("t3 err", err, 3'b100);
        check("t3 no done", done, 0);
        check("t3 mem_valid off", mem_valid, 0);
        req = 3'b000;
        step;
        check("t3 err once", err, 0);

        // contention: round robin 0,1,2,0,1,2 starting from pointer 0
        t2_addr[0] = 19'h0_0AAA;
        t2_addr[1] = 19'h5_5555;
        t2_addr[2] = 19'h7_FFFF;
        t2_we = 3'b010;
        for (int i = 0; i < NR; i++) set_addr(i, t2_addr[i]);
        req_we = t2_we;
        req = 3'b111;
        step;
        for (int t = 0; t < 6; t++) begin
            exp_i = t % 3;
            n = 0;
            while (!busy && n < 4) begin
                step;
                n++;
            end
            check("t2 grant wait", busy, 1);
            check("t2 gnt", gnt, 32'(1) << exp_i);
            check("t2 mem_addr", mem_addr, t2_addr[exp_i]);
            check("t2 mem_we", mem_we, t2_we[exp_i]);
            step;
            step;
            check("t2 hold valid", mem_valid, 1);
            mem_ready = 1'b1;
            step;
            mem_ready = 1'b0;
            check("t2 done", done, 32'(1) << exp_i);
            check("t2 err", err, 0);
            if (t == 5) req = 3'b000;
            else        req[exp_i] = 1'b0;
            step;
            if (t < 5) req[exp_i] = 1'b1;
        end
        check("t2 idle", busy, 0);

        // asynchronous reset in the middle of an ISSUE
        set_addr(1, 19'h1_5A5A);
        req = 3'b010;
        step;
        check("t6 gnt", gnt, 3'b010);
        step;
        check("t6 still issue", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6 async mem_valid", mem_valid, 0);
        check("t6 async gnt", gnt, 0);
        check("t6 async busy", busy, 0);
        set_addr(2, 19'h0_0777);
        req = 3'b100;
        step;
        check("t6 no done", done, 0);
        check("t6 no err", err, 0);
        rst_n = 1'b1;
        step;
        check("t6 regrant", gnt, 3'b100);
        check("t6 addr", mem_addr, 19'h0_0777);
        check("t6 stale done", done, 0);
        mem_ready = 1'b1;
        step;
        check("t6 done", done, 3'b100);
        req = 3'b000;
        mem_ready = 1'b0;
        step;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
